instr_register_pipe: RTL and testbench
======================================

# instr_register_pipe

- Parametrised successor of the instruction register: a DEPTH-entry store of {opcode, operand_a, operand_b}.
- Each written instruction is evaluated by an internal two-stage ALU pipeline. The result is written back into the same entry together with per-entry status (result valid, divide-by-zero).
- Reads use a registered request/response port. The block sits between the instruction-issue logic and any consumer that fetches computed results by index.

## Interface
Parameters:
- DEPTH, 32, number of entries; power of two, ≥ 2.
- OPERAND_W, 8, width of operand_a/operand_b (signed).
- PTR_W, $clog2(DEPTH), pointer width (derived localparam, not overridable).

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_en  in  1  write request, sampled on clk.
- write_pointer  in  PTR_W  entry to write.
- opcode  in  opcode_t  operation (ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD = 0..7).
- operand_a, operand_b  in  OPERAND_W  signed operands.
- read_en  in  1  read request.
- read_pointer  in  PTR_W  entry to read.
- read_valid  out  1  response strobe, one cycle per accepted read_en.
- read_err  out  1  entry has no valid result; qualified by read_valid.
- read_dz  out  1  entry result came from divide/mod by zero.
- read_opc  out  opcode_t; read_op_a, read_op_b  out  OPERAND_W; read_op_r  out  2*OPERAND_W signed.

## Operation
- Entry state: opc, op_a, op_b, op_r, res_valid, dz.
- Write at edge T (load_en=1):
  - Store opc/op_a/op_b; clear res_valid and dz.
  - Launch stage S1 {ptr, opc, a, b, tag_valid=1}.
- Pipeline:
  - S1→S2 at T+1: ALU result registered.
  - Writeback at T+2: op_r and dz written, res_valid set, only if the stage's tag_valid is still 1.
- Cancellation: a new write to pointer P kills every in-flight S1/S2 stage whose ptr==P (tag_valid←0), so an older result never overwrites a newer instruction.
- Arithmetic (all signed, result sign-extended to 2*OPERAND_W):
  - ZERO→0; PASSA→a; PASSB→b; ADD a+b; SUB a−b; MULT full product.
  - DIV/MOD truncate toward zero.
  - b==0 for DIV/MOD → op_r=0, dz=1.
- Read at edge E (read_en=1):
  - read_valid=1 at E; fields reflect entry state including a writeback committing at E (write-first forward).
  - If res_valid=0: read_err=1, read_op_r=0, other fields still reflect the stored instruction.
  - read_en=0: read_valid=0; other read_* outputs hold their last value.
- Simultaneous load_en and read_en to the same pointer at E: the read returns the pre-write entry (old instruction and old result).
- Write and writeback to the same pointer at the same edge: the new write wins; the writeback is already cancelled.

## Timing
- Write-to-result latency is 2 cycles. A read sampled at T+2 returns the result; a read at T+1 returns read_err=1.
- Throughput is one write and one read per cycle, with no stalls and no back-pressure.
- Reset (asynchronous, any time including mid-pipeline):
  - All entries: fields 0, res_valid=0, dz=0.
  - Pipeline tags cleared.
  - All outputs 0.
- Pointers wrap naturally modulo DEPTH (no out-of-range possible).

## Configuration
- INSTR_REG_MULDIV_EN:
  - Defined: MULT, DIV and MOD are implemented as above.
  - Undefined: no multiplier/divider is synthesised. MULT/DIV/MOD write op_r=0, dz=0, and res_valid=1 so that the read reports no error; opcode is still stored.

## Structure
- instr_register_pkg: opcode_t enum and the ALU latency constant (ALU_LAT=2).
- Sub-module instr_alu: registered S1→S2 compute with OPERAND_W parameter; inputs opc/a/b, outputs 2*OPERAND_W result and dz. The MULDIV macro applies inside it.
- Top holds the entry array, tag/cancel logic, writeback and read port.

## Test plan
(DEPTH=8, OPERAND_W=8)
- Reset: assert reset mid-burst of writes, then read all 8 entries → read_err=1, read_op_r=0 for every entry; all outputs 0 while reset is high.
- Latency: write ptr 3 ADD a=−5 b=7 at T; read ptr 3 at T+1 → read_err=1; read at T+2 → read_op_r=2, read_err=0.
- Full product: MULT a=−128 b=127 → read_op_r=−16256 (16-bit); DIV a=−9 b=2 → −4; MOD a=−9 b=2 → −1.
- Divide by zero: DIV a=9 b=0 → read_op_r=0, read_dz=1, read_err=0.
- Cancellation: write ptr 2 SUB a=10 b=3 at T, ptr 2 PASSA a=44 at T+1; reads ptr 2 at T+2 and onward → read_err=1 at T+2, then read_op_r=44 from T+3; 7 never appears.
- Macro off: MULT a=3 b=4 → read_op_r=0, read_err=0, read_dz=0.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types and constants for the instruction register pipeline.
//   opcode_t : 3-bit ALU operation code (ZERO..MOD = 0..7)
//   ALU_LAT  : cycles from an accepted write to its result being committed
package instr_register_pkg;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  localparam int unsigned ALU_LAT = 2;

endpackage

// File: rtl/instr_alu.sv
// Registered ALU stage: computes opc(a, b) combinationally and registers the
// sign-extended 2*OPERAND_W result plus the divide-by-zero flag.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   opc, a, b        : operation and signed operands
//   result, dz       : registered result and divide/mod-by-zero flag
// Build option: INSTR_REG_MULDIV_EN enables MULT/DIV/MOD; when undefined no
// multiplier or divider is built and those opcodes produce 0 with dz=0.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int unsigned OPERAND_W = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  opcode_t                        opc,
  input  logic signed [OPERAND_W-1:0]    a,
  input  logic signed [OPERAND_W-1:0]    b,
  output logic signed [2*OPERAND_W-1:0]  result,
  output logic                           dz
);

  localparam int unsigned RES_W = 2 * OPERAND_W;

  logic signed [RES_W-1:0] a_ext, b_ext, result_d;
  logic                    dz_d;

  // Extend before arithmetic so MULT and -MIN/-1 fit without overflow.
  assign a_ext = {{OPERAND_W{a[OPERAND_W-1]}}, a};
  assign b_ext = {{OPERAND_W{b[OPERAND_W-1]}}, b};

`ifdef INSTR_REG_MULDIV_EN
  logic                    b_zero;
  logic signed [RES_W-1:0] b_div, quot, rem;

  // Divisor forced to 1 on zero so the divider never sees x/0; the result
  // is discarded in that case anyway.
  assign b_zero = (b == '0);
  assign b_div  = b_zero ? RES_W'(1) : b_ext;
  assign quot   = a_ext / b_div;
  assign rem    = a_ext % b_div;
`endif

  always_comb begin
    result_d = '0;
    dz_d     = 1'b0;
    case (opc)
      ZERO:  result_d = '0;
      PASSA: result_d = a_ext;
      PASSB: result_d = b_ext;
      ADD:   result_d = a_ext + b_ext;
      SUB:   result_d = a_ext - b_ext;
`ifdef INSTR_REG_MULDIV_EN
      MULT:  result_d = a_ext * b_ext;
      DIV: begin
        result_d = b_zero ? '0 : quot;
        dz_d     = b_zero;
      end
      MOD: begin
        result_d = b_zero ? '0 : rem;
        dz_d     = b_zero;
      end
`endif
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      dz     <= 1'b0;
    end else begin
      result <= result_d;
      dz     <= dz_d;
    end
  end

endmodule

// File: rtl/instr_register_pipe.sv
// DEPTH-entry instruction store with a two-stage ALU pipeline writing results
// back into the entry, and a registered read request/response port.
// Ports:
//   clk, reset                         : clock, asynchronous active-high reset
//   load_en, write_pointer             : write request and target entry
//   opcode, operand_a, operand_b       : instruction to store and evaluate
//   read_en, read_pointer              : read request and entry index
//   read_valid                         : one-cycle response strobe
//   read_err, read_dz                  : no valid result / divide-by-zero
//   read_opc, read_op_a, read_op_b     : stored instruction fields
//   read_op_r                          : result (0 when read_err)
// Build option: INSTR_REG_MULDIV_EN (applied inside instr_alu).
module instr_register_pipe
  import instr_register_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned OPERAND_W = 8,
  localparam int unsigned PTR_W    = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load_en,
  input  logic [PTR_W-1:0]               write_pointer,
  input  opcode_t                        opcode,
  input  logic signed [OPERAND_W-1:0]    operand_a,
  input  logic signed [OPERAND_W-1:0]    operand_b,
  input  logic                           read_en,
  input  logic [PTR_W-1:0]               read_pointer,
  output logic                           read_valid,
  output logic                           read_err,
  output logic                           read_dz,
  output opcode_t                        read_opc,
  output logic signed [OPERAND_W-1:0]    read_op_a,
  output logic signed [OPERAND_W-1:0]    read_op_b,
  output logic signed [2*OPERAND_W-1:0]  read_op_r
);

  localparam int unsigned RES_W = 2 * OPERAND_W;

  // Entry array
  opcode_t                 entry_opc_q [DEPTH];
  logic signed [OPERAND_W-1:0] entry_a_q [DEPTH];
  logic signed [OPERAND_W-1:0] entry_b_q [DEPTH];
  logic signed [RES_W-1:0] entry_r_q   [DEPTH];
  logic [DEPTH-1:0]        entry_valid_q, entry_dz_q;

  // Pipeline stages
  logic [PTR_W-1:0]            s1_ptr_q, s2_ptr_q;
  opcode_t                     s1_opc_q;
  logic signed [OPERAND_W-1:0] s1_a_q, s1_b_q;
  logic                        s1_tag_q, s2_tag_q;
  logic signed [RES_W-1:0]     alu_result;
  logic                        alu_dz;

  // Read response registers
  logic                        read_valid_q, read_err_q, read_dz_q;
  opcode_t                     read_opc_q;
  logic signed [OPERAND_W-1:0] read_op_a_q, read_op_b_q;
  logic signed [RES_W-1:0]     read_op_r_q;

  logic                        s1_kill, wb_en;
  logic                        rd_fwd, rd_res_valid, rd_dz;
  logic signed [RES_W-1:0]     rd_r;

  instr_alu #(
    .OPERAND_W (OPERAND_W)
  ) u_alu (
    .clk    (clk),
    .reset  (reset),
    .opc    (s1_opc_q),
    .a      (s1_a_q),
    .b      (s1_b_q),
    .result (alu_result),
    .dz     (alu_dz)
  );

  // A new write to P kills any in-flight result for P, including one that
  // would commit at this same edge.
  assign s1_kill = load_en && (write_pointer == s1_ptr_q);
  assign wb_en   = s2_tag_q && !(load_en && (write_pointer == s2_ptr_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_tag_q <= 1'b0;
      s1_ptr_q <= '0;
      s1_opc_q <= ZERO;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s2_tag_q <= 1'b0;
      s2_ptr_q <= '0;
    end else begin
      s1_tag_q <= load_en;
      if (load_en) begin
        s1_ptr_q <= write_pointer;
        s1_opc_q <= opcode;
        s1_a_q   <= operand_a;
        s1_b_q   <= operand_b;
      end
      s2_tag_q <= s1_tag_q && !s1_kill;
      s2_ptr_q <= s1_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry_opc_q[i] <= ZERO;
        entry_a_q[i]   <= '0;
        entry_b_q[i]   <= '0;
        entry_r_q[i]   <= '0;
      end
      entry_valid_q <= '0;
      entry_dz_q    <= '0;
    end else begin
      if (wb_en) begin
        entry_r_q[s2_ptr_q]     <= alu_result;
        entry_dz_q[s2_ptr_q]    <= alu_dz;
        entry_valid_q[s2_ptr_q] <= 1'b1;
      end
      if (load_en) begin
        entry_opc_q[write_pointer]   <= opcode;
        entry_a_q[write_pointer]     <= operand_a;
        entry_b_q[write_pointer]     <= operand_b;
        entry_valid_q[write_pointer] <= 1'b0;
        entry_dz_q[write_pointer]    <= 1'b0;
      end
    end
  end

  // Read sees a writeback committing at the same edge; a write at the same
  // edge is not visible (entry registers still hold the old instruction).
  always_comb begin
    rd_fwd       = wb_en && (s2_ptr_q == read_pointer);
    rd_res_valid = rd_fwd || entry_valid_q[read_pointer];
    rd_r         = rd_fwd ? alu_result : entry_r_q[read_pointer];
    rd_dz        = rd_fwd ? alu_dz : entry_dz_q[read_pointer];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_valid_q <= 1'b0;
      read_err_q   <= 1'b0;
      read_dz_q    <= 1'b0;
      read_opc_q   <= ZERO;
      read_op_a_q  <= '0;
      read_op_b_q  <= '0;
      read_op_r_q  <= '0;
    end else begin
      read_valid_q <= read_en;
      if (read_en) begin
        read_err_q  <= !rd_res_valid;
        read_dz_q   <= rd_res_valid && rd_dz;
        read_opc_q  <= entry_opc_q[read_pointer];
        read_op_a_q <= entry_a_q[read_pointer];
        read_op_b_q <= entry_b_q[read_pointer];
        read_op_r_q <= rd_res_valid ? rd_r : '0;
      end
    end
  end

  assign read_valid = read_valid_q;
  assign read_err   = read_err_q;
  assign read_dz    = read_dz_q;
  assign read_opc   = read_opc_q;
  assign read_op_a  = read_op_a_q;
  assign read_op_b  = read_op_b_q;
  assign read_op_r  = read_op_r_q;

endmodule

// File: tb/tb_instr_register_pipe.sv
module tb_instr_register_pipe;
  import instr_register_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned W     = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_en;
  logic [2:0]        write_pointer;
  opcode_t           opcode;
  logic signed [7:0] operand_a, operand_b;
  logic              read_en;
  logic [2:0]        read_pointer;
  logic              read_valid, read_err, read_dz;
  opcode_t           read_opc;
  logic signed [7:0] read_op_a, read_op_b;
  logic signed [15:0] read_op_r;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_register_pipe #(
    .DEPTH     (DEPTH),
    .OPERAND_W (W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .load_en       (load_en),
    .write_pointer (write_pointer),
    .opcode        (opcode),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .read_en       (read_en),
    .read_pointer  (read_pointer),
    .read_valid    (read_valid),
    .read_err      (read_err),
    .read_dz       (read_dz),
    .read_opc      (read_opc),
    .read_op_a     (read_op_a),
    .read_op_b     (read_op_b),
    .read_op_r     (read_op_r)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic le, input logic [2:0] wp, input opcode_t op,
                       input logic signed [7:0] a, input logic signed [7:0] b,
                       input logic re, input logic [2:0] rp);
    load_en       = le;
    write_pointer = wp;
    opcode        = op;
    operand_a     = a;
    operand_b     = b;
    read_en       = re;
    read_pointer  = rp;
  endtask

  task automatic test_reset();
    logic [37:0] outs;
    reset = 1'b1;
    drive(1'b0, 3'd0, ZERO, 8'sd0, 8'sd0, 1'b0, 3'd0);
    tick();
    outs = {read_valid, read_err, read_dz, read_opc, read_op_a, read_op_b, read_op_r};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_hold: got %h want 0", outs);
    end
    reset = 1'b0;
    // Burst of writes with reads of entry 0 trailing behind
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'(i), ADD, 8'(i), 8'sd1, (i >= 2), 3'd0);
      tick();
    end
    checks++;
    if (read_valid !== 1'b1 || read_op_r !== 16'sd1 || read_opc !== ADD) begin
      failures++;
      $display("FAIL pre_reset_read: got valid=%b r=%0d opc=%0d want 1 1 3",
               read_valid, read_op_r, read_opc);
    end
    // Reset asserted mid-burst, between edges, with writes in flight
    drive(1'b1, 3'd5, ADD, 8'sd5, 8'sd1, 1'b1, 3'd0);
    reset = 1'b1;
    #1;
    outs = {read_valid, read_err, read_dz, read_opc, read_op_a, read_op_b, read_op_r};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_async: got %h want 0", outs);
    end
    tick();
    outs = {read_valid, read_err, read_dz, read_opc, read_op_a, read_op_b, read_op_r};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_held_edge: got %h want 0", outs);
    end
    drive(1'b0, 3'd0, ZERO, 8'sd0, 8'sd0, 1'b0, 3'd0);
    reset = 1'b0;
    repeat (ALU_LAT) tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'd0, ZERO, 8'sd0, 8'sd0, 1'b1, 3'(i));
      tick();
      outs = {read_valid, read_err, read_dz, read_opc, read_op_a, read_op_b, read_op_r};
      checks++;
      if (outs !== {1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 8'd0, 16'd0}) begin
        failures++;
        $display("FAIL reset_entry%0d: got %h want %h", i, outs,
                 {1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 8'd0, 16'd0});
      end
    end
  endtask

  task automatic test_latency();
    drive(1'b1, 3'd3, ADD, -8'sd5, 8'sd7, 1'b0, 3'd0);
    tick();  // T
    drive(1'b0, 3'd0, ZERO, 8'sd0, 8'sd0, 1'b1, 3'd3);
    tick();  // T+1
    checks++;
    if (read_valid !== 1'b1 || read_err !== 1'b1 || read_op_r !== 16'sd0 ||
        read_op_a !== -8'sd5 || read_opc !== ADD) begin
      failures++;
      $display("FAIL lat_t1: got v=%b err=%b r=%0d a=%0d opc=%0d want 1 1 0 -5 3",
               read_valid, read_err, read_op_r, read_op_a, read_opc);
    end
    tick();  // T+2
    checks++;
    if (read_valid !== 1'b1 || read_err !== 1'b0 || read_op_r !== 16'sd2 ||
        read_dz !== 1'b0 || read_op_b !== 8'sd7) begin
      failures++;
      $display("FAIL lat_t2: got v=%b err=%b r=%0d dz=%b b=%0d want 1 0 2 0 7",
               read_valid, read_err, read_op_r, read_dz, read_op_b);
    end
    drive(1'b0, 3'd0, ZERO, 8'sd0, 8'sd0, 1'b0, 3'd5);
    tick();
    checks++;
    if (read_valid !== 1'b0 || read_op_r !== 16'sd2 || read_opc !== ADD) begin
      failures++;
      $display("FAIL read_hold: got v=%b r=%0d opc=%0d want 0 2 3",
               read_valid, read_op_r, read_opc);
    end
  endtask

  task automatic test_muldiv();
    logic [2:0]         ptrs [5];
    logic signed [15:0] exp_r [5];
    logic               exp_dz [5];
    ptrs = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
`ifdef INSTR_REG_MULDIV_EN
    exp_r  = '{-16'sd16256, -16'sd4, -16'sd1, 16'sd0, 16'sd12};
    exp_dz = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    exp_r  = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    exp_dz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    drive(1'b1, 3'd4, MULT, -8'sd128, 8'sd127, 1'b0, 3'd0); tick();
    drive(1'b1, 3'd5, DIV,  -8'sd9,   8'sd2,   1'b0, 3'd0); tick();
    drive(1'b1, 3'd6, MOD,  -8'sd9,   8'sd2,   1'b0, 3'd0); tick();
    drive(1'b1, 3'd7, DIV,  8'sd9,    8'sd0,   1'b0, 3'd0); tick();
    drive(1'b1, 3'd1, MULT, 8'sd3,    8'sd4,   1'b0, 3'd0); tick();
    drive(1'b0, 3'd0, ZERO, 8'sd0, 8'sd0, 1'b0, 3'd0);
    repeat (ALU_LAT) tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 3'd0, ZERO, 8'sd0, 8'sd0, 1'b1, ptrs[i]);
      tick();
      checks++;
      if (read_valid !== 1'b1 || read_err !== 1'b0 || read_op_r !== exp_r[i] ||
          read_dz !== exp_dz[i]) begin
        failures++;
        $display("FAIL muldiv_ptr%0d: got v=%b err=%b r=%0d dz=%b want 1 0 %0d %b",
                 ptrs[i], read_valid, read_err, read_op_r, read_dz, exp_r[i], exp_dz[i]);
      end
    end
  endtask

  task automatic test_cancel();
    drive(1'b1, 3'd2, SUB, 8'sd10, 8'sd3, 1'b0, 3'd0);
    tick();  // T
    drive(1'b1, 3'd2, PASSA, 8'sd44, 8'sd0, 1'b0, 3'd0);
    tick();  // T+1
    drive(1'b0, 3'd0, ZERO, 8'sd0, 8'sd0, 1'b1, 3'd2);
    tick();  // T+2
    checks++;
    if (read_err !== 1'b1 || read_op_r !== 16'sd0 || read_opc !== PASSA ||
        read_op_a !== 8'sd44) begin
      failures++;
      $display("FAIL cancel_t2: got err=%b r=%0d opc=%0d a=%0d want 1 0 1 44",
               read_err, read_op_r, read_opc, read_op_a);
    end
    for (int i = 3; i < 5; i++) begin
      tick();
      checks++;
      if (read_err !== 1'b0 || read_op_r !== 16'sd44) begin
        failures++;
        $display("FAIL cancel_t%0d: got err=%b r=%0d want 0 44", i, read_err, read_op_r);
      end
    end
  endtask

  task automatic test_same_edge();
    // Entry 3 holds ADD -5,7 -> 2
    drive(1'b1, 3'd3, PASSB, 8'sd0, 8'sd9, 1'b1, 3'd3);
    tick();
    checks++;
    if (read_opc !== ADD || read_op_a !== -8'sd5 || read_op_r !== 16'sd2 ||
        read_err !== 1'b0) begin
      failures++;
      $display("FAIL same_edge_old: got opc=%0d a=%0d r=%0d err=%b want 3 -5 2 0",
               read_opc, read_op_a, read_op_r, read_err);
    end
    drive(1'b0, 3'd0, ZERO, 8'sd0, 8'sd0, 1'b1, 3'd3);
    tick();
    checks++;
    if (read_opc !== PASSB || read_op_b !== 8'sd9 || read_err !== 1'b1) begin
      failures++;
      $display("FAIL same_edge_new: got opc=%0d b=%0d err=%b want 2 9 1",
               read_opc, read_op_b, read_err);
    end
    tick();
    checks++;
    if (read_op_r !== 16'sd9 || read_err !== 1'b0) begin
      failures++;
      $display("FAIL same_edge_res: got r=%0d err=%b want 9 0", read_op_r, read_err);
    end
  endtask

  task automatic test_back_to_back();
    // Write SUB 10k,k to entry k each cycle; read entry k two cycles later -> 9k
    for (int i = 0; i < 6; i++) begin
      drive((i < 4), 3'(i), SUB, 8'(10 * i), 8'(i), (i >= 2), 3'(i - 2));
      tick();
      if (i >= 2) begin
        checks++;
        if (read_valid !== 1'b1 || read_err !== 1'b0 || read_op_r !== 16'(9 * (i - 2))) begin
          failures++;
          $display("FAIL b2b_ptr%0d: got v=%b err=%b r=%0d want 1 0 %0d",
                   i - 2, read_valid, read_err, read_op_r, 9 * (i - 2));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_muldiv();
    test_cancel();
    test_same_edge();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
